icmp_echo_queue: RTL

Parametrised multi-slot payload queue between the ICMP receive and transmit engines. It stores each received echo-request payload together with its ICMP identifier, sequence number and checksum. It then replays queued packets to the transmitter in arrival order, with tx_start_en / tx_req / tx_done handshaking and an enforced inter-packet gap. Bursts of pings no longer overwrite one another, and oversize, malformed or overflow packets are dropped and counted.

---
 rtl/icmp_echo_queue_if.sv | 40 ++++
 rtl/icmp_echo_queue.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/icmp_echo_queue_if.sv
// ICMP echo queue bus: receive-side payload stream and
// transmit-side start/request/done handshake.
interface icmp_echo_queue_if;
  logic        rec_en;
  logic [7:0]  rec_data;
  logic        rec_pkt_done;
  logic [15:0] rec_byte_num;
  logic [15:0] icmp_id;
  logic [15:0] icmp_seq;
  logic [31:0] reply_checksum;

  logic        tx_start_en;
  logic [15:0] tx_byte_num;
  logic [15:0] tx_icmp_id;
  logic [15:0] tx_icmp_seq;
  logic [31:0] tx_reply_checksum;
  logic        tx_req;
  logic [7:0]  tx_data;
  logic        tx_done;

  modport slave (
    input  rec_en, rec_data, rec_pkt_done,
    input  rec_byte_num, icmp_id, icmp_seq,
    input  reply_checksum,
    input  tx_req, tx_done,
    output tx_start_en, tx_byte_num,
    output tx_icmp_id, tx_icmp_seq,
    output tx_reply_checksum, tx_data
  );

  modport master (
    output rec_en, rec_data, rec_pkt_done,
    output rec_byte_num, icmp_id, icmp_seq,
    output reply_checksum,
    output tx_req, tx_done,
    input  tx_start_en, tx_byte_num,
    input  tx_icmp_id, tx_icmp_seq,
    input  tx_reply_checksum, tx_data
  );
endinterface

// File: rtl/icmp_echo_queue.sv
// Multi-slot FIFO of ICMP echo payloads between rx and tx.
// Bad, oversize or overflow packets are dropped and counted.
module icmp_echo_queue #(
  parameter int SLOT_NUM   = 4,
  parameter int SLOT_DEPTH = 2048,
  parameter int IFG_CYCLES = 12,
  parameter int TX_TIMEOUT = 65535,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  icmp_echo_queue_if.slave          bus,
  output logic [$clog2(SLOT_NUM):0] slot_used,
  output logic [CNT_W-1:0]          drop_cnt,
  output logic                      tx_timeout
);

  localparam int SW = $clog2(SLOT_NUM);
  localparam int OW = $clog2(SLOT_DEPTH);
  localparam int AW = SW + OW;
  localparam int TW = $clog2(TX_TIMEOUT + 1);
  localparam int GW = $clog2(IFG_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_SEND,
    S_GAP
  } state_e;

  logic [7:0] mem [SLOT_NUM*SLOT_DEPTH];

  logic [15:0] len_q [SLOT_NUM];
  logic [15:0] id_q  [SLOT_NUM];
  logic [15:0] seq_q [SLOT_NUM];
  logic [31:0] cs_q  [SLOT_NUM];

  logic [SW:0]      used_q, used_d;
  logic [SW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [OW:0]      wr_off_q;
  logic             in_pkt_q, discard_q, over_q;
  logic [CNT_W-1:0] drop_q;

  state_e      state_q, state_d;
  logic [15:0] rd_off_q;
  logic [7:0]  tx_data_q;
  logic [TW-1:0] tmo_q;
  logic [GW-1:0] gap_q;

  logic          first, full, discard_now;
  logic          room, wr_acc, over_now;
  logic [OW:0]   byte_cnt;
  logic [16:0]   cnt_ext;
  logic          commit, drop;
  logic [AW-1:0] waddr, raddr;
  logic [15:0]   cur_len;
  logic          rd_in_range;
  logic          tmo_hit, free;

  // Write-side admission and commit decision for the current packet
  always_comb begin
    first       = bus.rec_en & ~in_pkt_q;
    full        = (used_q == (SW+1)'(SLOT_NUM));
    discard_now = first ? full : discard_q;
    room        = (wr_off_q != (OW+1)'(SLOT_DEPTH));
    wr_acc      = bus.rec_en & ~discard_now & room;
    over_now    = over_q |
                  (bus.rec_en & ~discard_now & ~room);
    byte_cnt    = wr_off_q + {{OW{1'b0}}, wr_acc};
    cnt_ext     = 17'(byte_cnt);
    commit      = bus.rec_pkt_done & ~discard_now &
                  ~over_now & (byte_cnt != '0) &
                  (cnt_ext == {1'b0, bus.rec_byte_num});
    drop        = bus.rec_pkt_done & ~commit;
    waddr       = {wr_ptr_q, wr_off_q[OW-1:0]};
  end

  // Slot occupancy: commit and free may coincide
  always_comb begin
    used_d = used_q;
    unique case (1'b1)
      commit & ~free: used_d = used_q + (SW+1)'(1);
      free & ~commit: used_d = used_q - (SW+1)'(1);
      default:        used_d = used_q;
    endcase
  end

  // Receive bookkeeping, metadata latch and drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_pkt_q  <= 1'b0;
      discard_q <= 1'b0;
      over_q    <= 1'b0;
      wr_off_q  <= '0;
      wr_ptr_q  <= '0;
      used_q    <= '0;
      drop_q    <= '0;
      for (int i = 0; i < SLOT_NUM; i++) begin
        len_q[i] <= '0;
        id_q[i]  <= '0;
        seq_q[i] <= '0;
        cs_q[i]  <= '0;
      end
    end else begin
      used_q <= used_d;
      if (bus.rec_pkt_done) begin
        in_pkt_q  <= 1'b0;
        discard_q <= 1'b0;
        over_q    <= 1'b0;
        wr_off_q  <= '0;
      end else begin
        if (bus.rec_en) in_pkt_q <= 1'b1;
        if (first) discard_q <= full;
        over_q <= over_now;
        if (wr_acc) wr_off_q <= wr_off_q + (OW+1)'(1);
      end
      if (commit) begin
        wr_ptr_q        <= wr_ptr_q + SW'(1);
        len_q[wr_ptr_q] <= bus.rec_byte_num;
        id_q[wr_ptr_q]  <= bus.icmp_id;
        seq_q[wr_ptr_q] <= bus.icmp_seq;
        cs_q[wr_ptr_q]  <= bus.reply_checksum;
      end
      if (drop && !(&drop_q))
        drop_q <= drop_q + CNT_W'(1);
    end
  end

  // Payload RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_acc) mem[waddr] <= bus.rec_data;
  end

  // Read FSM next state and transmit-side outputs
  always_comb begin
    state_d               = state_q;
    cur_len               = len_q[rd_ptr_q];
    rd_in_range           = (rd_off_q < cur_len);
    raddr                 = {rd_ptr_q, rd_off_q[OW-1:0]};
    tmo_hit               = (tmo_q == TW'(TX_TIMEOUT - 1));
    free                  = 1'b0;
    tx_timeout            = 1'b0;
    bus.tx_start_en       = 1'b0;
    bus.tx_byte_num       = '0;
    bus.tx_icmp_id        = '0;
    bus.tx_icmp_seq       = '0;
    bus.tx_reply_checksum = '0;
    unique case (state_q)
      S_IDLE: begin
        if (used_q != '0) state_d = S_START;
      end
      S_START: begin
        bus.tx_start_en = 1'b1;
        state_d         = S_SEND;
      end
      S_SEND: begin
        if (bus.tx_done) begin
          free    = 1'b1;
          state_d = S_GAP;
        end else if (tmo_hit) begin
          free       = 1'b1;
          tx_timeout = 1'b1;
          state_d    = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == GW'(IFG_CYCLES - 1))
          state_d = (used_q != '0) ? S_START : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q == S_START || state_q == S_SEND) begin
      bus.tx_byte_num       = cur_len;
      bus.tx_icmp_id        = id_q[rd_ptr_q];
      bus.tx_icmp_seq       = seq_q[rd_ptr_q];
      bus.tx_reply_checksum = cs_q[rd_ptr_q];
    end
  end

  // Read FSM state, byte fetch, timeout and gap counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rd_ptr_q  <= '0;
      rd_off_q  <= '0;
      tx_data_q <= '0;
      tmo_q     <= '0;
      gap_q     <= '0;
    end else begin
      state_q <= state_d;
      if (free) rd_ptr_q <= rd_ptr_q + SW'(1);
      if (state_q == S_START) begin
        rd_off_q <= '0;
        tmo_q    <= '0;
      end else if (state_q == S_SEND) begin
        tmo_q <= tmo_q + TW'(1);
        if (bus.tx_req) begin
          if (rd_in_range) begin
            tx_data_q <= mem[raddr];
            rd_off_q  <= rd_off_q + 16'd1;
          end else begin
            tx_data_q <= '0;
          end
        end
      end
      if (state_q == S_GAP) gap_q <= gap_q + GW'(1);
      else                  gap_q <= '0;
    end
  end

  assign bus.tx_data = tx_data_q;
  assign slot_used   = used_q;
  assign drop_cnt    = drop_q;

endmodule
